ksadd_share_arbiter: RTL
========================

Name: ksadd_share_arbiter

Overview:
- Shares one 16-bit Kogge-Stone adder instance among 4 requesters.
- Round-robin arbitration; per-requester valid/ready request and response handshakes.
- Operands are registered and held stable while the adder settles for ADD_LAT cycles; the result is captured and returned to the owner.
- Sits between client blocks and the single adder instance. The adder's ports are driven as packed buses here; the top level splits them into bit ports.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADD_LAT, 2, settle cycles the adder is given before the sum is sampled (1..15).

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester request accepted (one-hot or zero)
- req_a  in  16*NREQ  packed operand A, requester i at [16i+15:16i]
- req_b  in  16*NREQ  packed operand B, same packing
- req_cin  in  NREQ  per-requester carry-in
- resp_valid  out  NREQ  result valid for owner (one-hot or zero)
- resp_ready  in  NREQ  per-requester result accept
- resp_sum  out  16  result word, shared by all requesters
- add_a  out  16  to adder k inputs
- add_b  out  16  to adder t inputs
- add_cin  out  1  to adder cin
- add_sum  in  16  from adder s outputs
- busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, EXEC, RESP. Reset: state=IDLE, rr_ptr=0, owner=0, cnt=0, add_a/add_b/add_cin=0, resp_sum=0, all req_ready/resp_valid=0, busy=0.
- Reset is synchronous and overrides everything. Reset mid-EXEC or mid-RESP drops the transaction with no response and returns to IDLE next cycle.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other ready bits are 0. req_ready is never high outside IDLE.
  - On the edge: owner<=winner; add_a/add_b/add_cin <= winner's operands; cnt<=ADD_LAT-1; go EXEC.
  - If no req_valid bit is set, stay in IDLE.
- EXEC:
  - add_a/add_b/add_cin held constant.
  - If cnt=0: resp_sum<=add_sum and go RESP. Otherwise cnt<=cnt-1.
  - Accept-to-sample latency is ADD_LAT cycles.
- RESP:
  - resp_valid[owner]=1 (registered, asserted from RESP entry); resp_sum held.
  - When resp_ready[owner]=1: resp_valid drops on the next edge, rr_ptr<=(owner+1) mod NREQ, go IDLE.
  - resp_ready on non-owner lines is ignored.
- Pointer update happens only on response completion, never on grant.
- Throughput: one transaction per ADD_LAT+2 cycles minimum (IDLE, ADD_LAT×EXEC, RESP with immediate ready).
- Arithmetic: resp_sum = add_sum as delivered by the adder. The arbiter performs no arithmetic and no width extension.
- A requester may drop req_valid before it is granted; that is legal and causes no grant. Operands are sampled only on the grant edge, so later changes have no effect.
- Simultaneous requests are resolved purely by rr_ptr order; no requester is starved (bounded wait ≤ NREQ-1 transactions).
- add_* outputs keep their last values in IDLE. They are not cleared between transactions.

Test Plan:
- Reset, then a single request: reset 2 cycles; req_valid=0001, a0=0x1234, b0=0x0101, cin0=0 -> req_ready=0001 in that cycle; add_a=0x1234 held 2 cycles; resp_valid=0001 with resp_sum=adder output (0x1335 with a behavioural adder) 3 cycles after grant.
- Round-robin fairness: req_valid=1111 held continuously, resp_ready=1111 -> grants in order 0,1,2,3,0; each grant 4 cycles apart with ADD_LAT=2.
- Pointer skip: rr_ptr=1 after serving req0; req_valid=1001 -> req3 granted before req0.
- Response backpressure: resp_ready[owner]=0 for 5 cycles -> resp_valid and resp_sum stay stable, no new req_ready, busy=1; on ready, IDLE the next cycle.
- Reset mid-EXEC: assert reset one cycle after grant -> next cycle state IDLE, all outputs at reset values, no resp_valid ever seen for the dropped transaction, rr_ptr=0.
- Operand change after grant: change a0 to 0xFFFF in the cycle after grant -> add_a stays at the original value; resp_sum reflects the original operands.

Source files
------------

// File: rtl/ksadd_share_arbiter.sv
// Round-robin front end that time-shares one 16-bit Kogge-Stone adder among NREQ clients.
// States: IDLE = wait for a request | EXEC = operands held while adder settles | RESP = result offered to owner
module ksadd_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_cin,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [15:0]          resp_sum,
  output logic [15:0]          add_a,
  output logic [15:0]          add_b,
  output logic                 add_cin,
  input  logic [15:0]          add_sum,
  output logic                 busy
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  state_e            state_q;
  logic [PW-1:0]     rr_ptr_q;
  logic [PW-1:0]     owner_q;
  logic [3:0]        cnt_q;
  logic [15:0]       add_a_q;
  logic [15:0]       add_b_q;
  logic              add_cin_q;
  logic [15:0]       resp_sum_q;
  logic [NREQ-1:0]   resp_valid_q;

  logic              found;
  logic [PW-1:0]     winner;
  logic [PW-1:0]     cand;
  logic [15:0]       a_arr [NREQ];
  logic [15:0]       b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[16*i+15:16*i];
    assign b_arr[i] = req_b[16*i+15:16*i];
  end

  // First requester found walking upward from rr_ptr with wrap-around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && found) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      add_cin_q    <= 1'b0;
      resp_sum_q   <= '0;
      resp_valid_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found) begin
            owner_q   <= winner;
            add_a_q   <= a_arr[winner];
            add_b_q   <= b_arr[winner];
            add_cin_q <= req_cin[winner];
            cnt_q     <= 4'(ADD_LAT - 1);
            state_q   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt_q == 4'd0) begin
            resp_sum_q            <= add_sum;
            resp_valid_q[owner_q] <= 1'b1;
            state_q               <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          // Pointer advances only once the owner has taken its result.
          if (resp_ready[owner_q]) begin
            resp_valid_q <= '0;
            rr_ptr_q     <= (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign add_cin    = add_cin_q;
  assign resp_sum   = resp_sum_q;
  assign resp_valid = resp_valid_q;
  assign busy       = (state_q != S_IDLE);

endmodule
